// File: rtl/control_filtro_pb_pkg.sv
// Shared types and constants for the biquad low-pass sequencer: state encoding,
// operand-mux codes and the decoded control word.
package control_filtro_pb_pkg;

  typedef enum logic [3:0] {
    StIdle  = 4'd0,
    StShift = 4'd1,
    StM1    = 4'd2,
    StM2    = 4'd3,
    StM3    = 4'd4,
    StM4    = 4'd5,
    StM5    = 4'd6,
    StM6    = 4'd7,
    StM7    = 4'd8,
    StDone  = 4'd9
  } estado_e;

  // Multiplicand select
  localparam logic [2:0] S_FK  = 3'd0;
  localparam logic [2:0] S_FK1 = 3'd1;
  localparam logic [2:0] S_FK2 = 3'd2;
  localparam logic [2:0] S_UK  = 3'd3;

  // Coefficient select
  localparam logic [1:0] C_A1 = 2'd0;
  localparam logic [1:0] C_A2 = 2'd1;
  localparam logic [1:0] C_G  = 2'd2;
  localparam logic [1:0] C_B0 = 2'd3;

  // Addend select
  localparam logic [2:0] Z_CERO = 3'd0;
  localparam logic [2:0] Z_AC1  = 3'd1;
  localparam logic [2:0] Z_AC2  = 3'd2;
  localparam logic [2:0] Z_AC3  = 3'd3;
  localparam logic [2:0] Z_YK   = 3'd4;

  typedef struct packed {
    logic [7:1] en;
    logic [2:0] sel_s;
    logic [1:0] sel_c;
    logic [2:0] sel_z;
    logic       busy;
    logic       done;
  } ctrl_t;

endpackage

// File: rtl/control_filtro_pb_decodpasos.sv
// Combinational microprogram decoder: maps the sequencer state onto register
// enables, operand-mux selects and the busy/done status.
module control_filtro_pb_decodpasos
  import control_filtro_pb_pkg::*;
(
  input  estado_e i_estado,
  output ctrl_t   o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    unique case (i_estado)
      StShift: begin
        // F2 <- F1 and F1 <- F happen on the same edge
        o_ctrl.en[3] = 1'b1;
        o_ctrl.en[4] = 1'b1;
        o_ctrl.busy  = 1'b1;
      end
      StM1: begin
        o_ctrl.en[5] = 1'b1;
        o_ctrl.sel_s = S_FK1;
        o_ctrl.sel_c = C_A1;
        o_ctrl.sel_z = Z_CERO;
        o_ctrl.busy  = 1'b1;
      end
      StM2: begin
        o_ctrl.en[6] = 1'b1;
        o_ctrl.sel_s = S_FK2;
        o_ctrl.sel_c = C_A2;
        o_ctrl.sel_z = Z_AC1;
        o_ctrl.busy  = 1'b1;
      end
      StM3: begin
        o_ctrl.en[2] = 1'b1;
        o_ctrl.sel_s = S_UK;
        o_ctrl.sel_c = C_G;
        o_ctrl.sel_z = Z_AC2;
        o_ctrl.busy  = 1'b1;
      end
      StM4: begin
        o_ctrl.en[7] = 1'b1;
        o_ctrl.sel_s = S_FK;
        o_ctrl.sel_c = C_B0;
        o_ctrl.sel_z = Z_CERO;
        o_ctrl.busy  = 1'b1;
      end
      StM5: begin
        o_ctrl.en[5] = 1'b1;
        o_ctrl.sel_s = S_FK1;
        o_ctrl.sel_c = C_B0;
        o_ctrl.sel_z = Z_AC3;
        o_ctrl.busy  = 1'b1;
      end
      StM6: begin
        o_ctrl.en[6] = 1'b1;
        o_ctrl.sel_s = S_FK1;
        o_ctrl.sel_c = C_B0;
        o_ctrl.sel_z = Z_AC1;
        o_ctrl.busy  = 1'b1;
      end
      StM7: begin
        o_ctrl.en[1] = 1'b1;
        o_ctrl.sel_s = S_FK2;
        o_ctrl.sel_c = C_B0;
        o_ctrl.sel_z = Z_AC2;
        o_ctrl.busy  = 1'b1;
      end
      StDone: o_ctrl.done = 1'b1;
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/control_filtro_pb.sv
// Biquad low-pass sequencer: IDLE until a tick, then an 8-cycle shift/compute
// microprogram ending in a DONE pulse. FILTRO_OVERRUN_EN builds dropped-tick detection.
module control_filtro_pb
  import control_filtro_pb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  output logic       o_en1,
  output logic       o_en2,
  output logic       o_en3,
  output logic       o_en4,
  output logic       o_en5,
  output logic       o_en6,
  output logic       o_en7,
  output logic [2:0] o_selmux_s,
  output logic [1:0] o_selmux_c,
  output logic [2:0] o_selmux_z,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_overrun
);

  estado_e r_estado;
  estado_e w_estado_sig;
  ctrl_t   w_ctrl;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_estado <= StIdle;
    end else begin
      r_estado <= w_estado_sig;
    end
  end

  always_comb begin
    w_estado_sig = r_estado;
    unique case (r_estado)
      StIdle:  if (i_tick) w_estado_sig = StShift;
      StShift: w_estado_sig = StM1;
      StM1:    w_estado_sig = StM2;
      StM2:    w_estado_sig = StM3;
      StM3:    w_estado_sig = StM4;
      StM4:    w_estado_sig = StM5;
      StM5:    w_estado_sig = StM6;
      StM6:    w_estado_sig = StM7;
      StM7:    w_estado_sig = StDone;
      // A tick in DONE starts the next sample with no IDLE gap
      StDone:  w_estado_sig = i_tick ? StShift : StIdle;
      default: w_estado_sig = StIdle;
    endcase
  end

  control_filtro_pb_decodpasos u_decodpasos (
    .i_estado (r_estado),
    .o_ctrl   (w_ctrl)
  );

  assign o_en1      = w_ctrl.en[1];
  assign o_en2      = w_ctrl.en[2];
  assign o_en3      = w_ctrl.en[3];
  assign o_en4      = w_ctrl.en[4];
  assign o_en5      = w_ctrl.en[5];
  assign o_en6      = w_ctrl.en[6];
  assign o_en7      = w_ctrl.en[7];
  assign o_selmux_s = w_ctrl.sel_s;
  assign o_selmux_c = w_ctrl.sel_c;
  assign o_selmux_z = w_ctrl.sel_z;
  assign o_busy     = w_ctrl.busy;
  assign o_done     = w_ctrl.done;

`ifdef FILTRO_OVERRUN_EN
  logic r_overrun;

  // busy spans exactly SHIFT..M7, the window in which a tick is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_tick && w_ctrl.busy) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_overrun = r_overrun;
`else
  assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_control_filtro_pb.sv
// Self-checking bench for control_filtro_pb: table-driven tick/next-step vectors,
// a scoreboard of expected control words and a small fixed-point datapath model.
module tb_control_filtro_pb;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_tick;
  logic       o_en1, o_en2, o_en3, o_en4, o_en5, o_en6, o_en7;
  logic [2:0] o_selmux_s;
  logic [1:0] o_selmux_c;
  logic [2:0] o_selmux_z;
  logic       o_busy, o_done, o_overrun;

  control_filtro_pb dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_tick     (i_tick),
    .o_en1      (o_en1),
    .o_en2      (o_en2),
    .o_en3      (o_en3),
    .o_en4      (o_en4),
    .o_en5      (o_en5),
    .o_en6      (o_en6),
    .o_en7      (o_en7),
    .o_selmux_s (o_selmux_s),
    .o_selmux_c (o_selmux_c),
    .o_selmux_z (o_selmux_z),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overrun  (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  // Q4 fixed-point datapath: g=1.0, -a1=0.5, -a2=-0.25, b0=0.25, U=1.0
  int f, f1, f2, ac1, ac2, ac3, y;
  int sv, cv, zv, res;

  always_comb begin
    sv = 0;
    cv = 0;
    zv = 0;
    case (o_selmux_s)
      3'd0: sv = f;
      3'd1: sv = f1;
      3'd2: sv = f2;
      3'd3: sv = 16;
      default: sv = 0;
    endcase
    case (o_selmux_c)
      2'd0: cv = 8;
      2'd1: cv = -4;
      2'd2: cv = 16;
      default: cv = 4;
    endcase
    case (o_selmux_z)
      3'd1: zv = ac1;
      3'd2: zv = ac2;
      3'd3: zv = ac3;
      3'd4: zv = y;
      default: zv = 0;
    endcase
    res = (sv * cv) / 16 + zv;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f <= 0; f1 <= 0; f2 <= 0; ac1 <= 0; ac2 <= 0; ac3 <= 0; y <= 0;
    end else begin
      if (o_en4) f2 <= f1;
      if (o_en3) f1 <= f;
      if (o_en2) f <= res;
      if (o_en5) ac1 <= res;
      if (o_en6) ac2 <= res;
      if (o_en7) ac3 <= res;
      if (o_en1) y <= res;
    end
  end

  typedef struct {
    logic tick;
    int   nxt;
  } vec_t;

  typedef struct {
    logic [16:0] v;
    logic        ovr;
    int          stp;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb_q[$];
  logic [16:0] tab[10];
  int          exp_f[2];
  int          exp_y[2];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_samp = 0;
  int          cur = 0;
  logic        ovr_m = 1'b0;

  function automatic logic [16:0] mk(logic [7:1] en, logic [2:0] s, logic [1:0] c,
                                     logic [2:0] z, logic b, logic d);
    return {en, s, c, z, b, d};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {o_en7, o_en6, o_en5, o_en4, o_en3, o_en2, o_en1,
            o_selmux_s, o_selmux_c, o_selmux_z, o_busy, o_done, o_overrun};
  endfunction

  function automatic void add(logic t, int n);
    vec_t v;
    v.tick = t;
    v.nxt  = n;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Check the current cycle, then drive tick and queue the next cycle's expectation
  task automatic step(input logic t, input int n);
    sb_t e;
    @(negedge i_clk);
    if (sb_q.size() == 0) begin
      n_chk++;
      $display("FAIL sb_empty: got no entry expected one");
    end else begin
      e = sb_q.pop_front();
      chk($sformatf("outs_st%0d", e.stp), int'(dut_vec()), int'({e.v, e.ovr}));
      if (e.stp == 9 && n_samp < 2) begin
        chk($sformatf("fk_s%0d", n_samp), f, exp_f[n_samp]);
        chk($sformatf("yk_s%0d", n_samp), y, exp_y[n_samp]);
        n_samp++;
      end
    end
    i_tick = t;
`ifdef FILTRO_OVERRUN_EN
    if (t && cur >= 1 && cur <= 8) ovr_m = 1'b1;
`endif
    cur = n;
    e.v   = tab[n];
    e.ovr = ovr_m;
    e.stp = n;
    sb_q.push_back(e);
  endtask

  // Hold reset for a few cycles checking outputs are zero, release on a falling edge
  task automatic hold_reset(input int cycles);
    i_rst_n = 1'b0;
    i_tick  = 1'b0;
    #1;
    chk("rst_async", int'(dut_vec()), 0);
    sb_q.delete();
    cur    = 0;
    ovr_m  = 1'b0;
    n_samp = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge i_clk);
      chk("rst_hold", int'(dut_vec()), 0);
    end
    i_rst_n = 1'b1;
    sb_q.push_back('{tab[0], 1'b0, 0});
  endtask

  initial begin
    sb_t e;
    tab[0] = mk(7'b0000000, 3'd0, 2'd0, 3'd0, 1'b0, 1'b0);
    tab[1] = mk(7'b0001100, 3'd0, 2'd0, 3'd0, 1'b1, 1'b0);
    tab[2] = mk(7'b0010000, 3'd1, 2'd0, 3'd0, 1'b1, 1'b0);
    tab[3] = mk(7'b0100000, 3'd2, 2'd1, 3'd1, 1'b1, 1'b0);
    tab[4] = mk(7'b0000010, 3'd3, 2'd2, 3'd2, 1'b1, 1'b0);
    tab[5] = mk(7'b1000000, 3'd0, 2'd3, 3'd0, 1'b1, 1'b0);
    tab[6] = mk(7'b0010000, 3'd1, 2'd3, 3'd3, 1'b1, 1'b0);
    tab[7] = mk(7'b0100000, 3'd1, 2'd3, 3'd1, 1'b1, 1'b0);
    tab[8] = mk(7'b0000001, 3'd2, 2'd3, 3'd2, 1'b1, 1'b0);
    tab[9] = mk(7'b0000000, 3'd0, 2'd0, 3'd0, 1'b0, 1'b1);
    exp_f[0] = 16;  exp_y[0] = 4;
    exp_f[1] = 24;  exp_y[1] = 14;

    // Idle, then a single sample
    for (int i = 0; i < 3; i++) add(1'b0, 0);
    add(1'b1, 1);
    for (int s = 2; s <= 9; s++) add(1'b0, s);
    add(1'b0, 0);
    // Back-to-back: second tick lands in DONE
    add(1'b1, 1);
    for (int s = 2; s <= 9; s++) add(1'b0, s);
    add(1'b1, 1);
    for (int s = 2; s <= 9; s++) add(1'b0, s);
    add(1'b0, 0);
    // Tick during M3 is dropped
    add(1'b1, 1);
    add(1'b0, 2);
    add(1'b0, 3);
    add(1'b0, 4);
    add(1'b1, 5);
    for (int s = 6; s <= 9; s++) add(1'b0, s);
    add(1'b0, 0);
    add(1'b0, 0);

    i_tick = 1'b0;
    hold_reset(3);
    foreach (vecs[i]) step(vecs[i].tick, vecs[i].nxt);

    // Reset in the middle of M4, then a clean sample
    step(1'b1, 1);
    for (int s = 2; s <= 5; s++) step(1'b0, s);
    @(negedge i_clk);
    e = sb_q.pop_front();
    chk("pre_rst_m4", int'(dut_vec()), int'({e.v, e.ovr}));
    hold_reset(2);
    step(1'b1, 1);
    for (int s = 2; s <= 9; s++) step(1'b0, s);
    step(1'b0, 0);
    step(1'b0, 0);
    step(1'b0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
